cdb_arbiter: RTL and testbench

- Upstream producer of the common data bus (CDB) consumed by every reservation-station entry (`cdb_valid`, `cdb_in` wake-up inputs).
- Collects completion tags (destination physical register addresses) from NUM_SRC functional units.
- Buffers one tag per source and broadcasts exactly one tag per cycle, chosen round-robin, on a registered CDB output.

---
 rtl/cdb_arbiter.sv | 138 +++++++++++++
 tb/tb_cdb_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cdb_arbiter
// Description : Common-data-bus arbiter. Holds one completion tag per
//               functional unit and broadcasts one tag per cycle on a
//               registered CDB output, chosen round-robin.
//               Optional macro CDB_FIXED_PRIORITY_EN: lowest-index full slot
//               always wins and the round-robin pointer is not built.
// Revision    : 1.0 - initial release
// ============================================================================
module cdb_arbiter #(
  parameter int NUM_SRC             = 4,
  parameter int REG_FILE_ADDR_WIDTH = 7,
  parameter int SRC_IDX_WIDTH       = $clog2(NUM_SRC)
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   flush,
  input  logic [NUM_SRC-1:0]                     src_valid,
  input  logic [NUM_SRC*REG_FILE_ADDR_WIDTH-1:0] src_tag,
  output logic [NUM_SRC-1:0]                     src_ready,
  output logic                                   cdb_valid,
  output logic [REG_FILE_ADDR_WIDTH-1:0]         cdb_out,
  output logic [SRC_IDX_WIDTH-1:0]               cdb_src
);

  // Distance of a slot from the search start; one extra bit so that
  // (index + NUM_SRC) cannot overflow before the subtraction.
  localparam int c_DIST_W = SRC_IDX_WIDTH + 1;

  logic [NUM_SRC-1:0]             w_slot_full;
  logic [NUM_SRC-1:0]             w_grant;
  logic [NUM_SRC-1:0]             w_xfer;
  logic                           w_gnt_any;
  logic [c_DIST_W-1:0]            w_dist    [NUM_SRC];
  logic [SRC_IDX_WIDTH-1:0]       w_idx_acc [NUM_SRC+1];
  logic [REG_FILE_ADDR_WIDTH-1:0] w_tag_acc [NUM_SRC+1];

  logic                           r_cdb_valid;
  logic [REG_FILE_ADDR_WIDTH-1:0] r_cdb_out;
  logic [SRC_IDX_WIDTH-1:0]       r_cdb_src;

`ifdef CDB_FIXED_PRIORITY_EN
  // Fixed priority: search order is simply the slot index.
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_dist
    assign w_dist[gi] = c_DIST_W'(gi);
  end
`else
  logic [SRC_IDX_WIDTH-1:0] r_rr_ptr;
  logic [c_DIST_W-1:0]      w_ptr_ext;

  assign w_ptr_ext = {1'b0, r_rr_ptr};

  // Round-robin: search order is the slot's distance past rr_ptr, mod NUM_SRC.
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_dist
    assign w_dist[gi] = (c_DIST_W'(gi) >= w_ptr_ext) ? (c_DIST_W'(gi) - w_ptr_ext)
                                                     : (c_DIST_W'(gi + NUM_SRC) - w_ptr_ext);
  end

  // Pointer moves one past the winner; cleared by reset or flush.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      r_rr_ptr <= '0;
    end else if (w_gnt_any) begin
      r_rr_ptr <= (w_idx_acc[NUM_SRC] == SRC_IDX_WIDTH'(NUM_SRC - 1)) ? '0
                                                                       : w_idx_acc[NUM_SRC] + 1'b1;
    end
  end
`endif

  // A full slot wins when no other full slot sits earlier in the search order.
  // Depends only on slot state, never on src_valid, so no comb loop through ready.
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_grant
    logic [NUM_SRC-1:0] w_blk;
    for (genvar gj = 0; gj < NUM_SRC; gj++) begin : g_cmp
      assign w_blk[gj] = w_slot_full[gj] && (w_dist[gj] < w_dist[gi]);
    end
    assign w_grant[gi] = w_slot_full[gi] && ~|w_blk;
  end

  assign w_gnt_any = |w_grant;

  // Grant is one-hot or zero, so OR-accumulating masked terms acts as a mux.
  assign w_idx_acc[0] = '0;
  assign w_tag_acc[0] = '0;
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_enc
    assign w_idx_acc[gi+1] = w_idx_acc[gi] | (w_grant[gi] ? SRC_IDX_WIDTH'(gi) : '0);
    assign w_tag_acc[gi+1] = w_tag_acc[gi] | (w_grant[gi] ? g_slot[gi].r_tag : '0);
  end

  // A slot being drained this cycle may reload in the same cycle.
  assign src_ready = {NUM_SRC{~flush & ~reset}} & (~w_slot_full | w_grant);
  assign w_xfer    = src_valid & src_ready;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_slot
    logic                           r_full;
    logic [REG_FILE_ADDR_WIDTH-1:0] r_tag;

    // Occupancy: a new transfer beats the drain of a granted slot.
    always_ff @(posedge clock) begin
      if (reset || flush) begin
        r_full <= 1'b0;
      end else if (w_xfer[gi]) begin
        r_full <= 1'b1;
      end else if (w_grant[gi]) begin
        r_full <= 1'b0;
      end
    end

    // Tag payload is only meaningful while r_full is set.
    always_ff @(posedge clock) begin
      if (w_xfer[gi]) begin
        r_tag <= src_tag[gi*REG_FILE_ADDR_WIDTH +: REG_FILE_ADDR_WIDTH];
      end
    end

    assign w_slot_full[gi] = r_full;
  end

  // Registered broadcast; zeros when nothing is granted.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      r_cdb_valid <= 1'b0;
      r_cdb_out   <= '0;
      r_cdb_src   <= '0;
    end else begin
      r_cdb_valid <= w_gnt_any;
      r_cdb_out   <= w_tag_acc[NUM_SRC];
      r_cdb_src   <= w_idx_acc[NUM_SRC];
    end
  end

  assign cdb_valid = r_cdb_valid;
  assign cdb_out   = r_cdb_out;
  assign cdb_src   = r_cdb_src;

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cdb_arbiter
// Description : Self-checking bench for cdb_arbiter: directed scenarios with
//               literal expectations plus randomized traffic against a
//               behavioural slot/pointer model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;
  localparam int N  = 4;
  localparam int W  = 7;
  localparam int IW = 2;

  logic           clock;
  logic           reset;
  logic           flush;
  logic [N-1:0]   src_valid;
  logic [N*W-1:0] src_tag;
  logic [N-1:0]   src_ready;
  logic           cdb_valid;
  logic [W-1:0]   cdb_out;
  logic [IW-1:0]  cdb_src;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model state
  bit           m_full [N];
  logic [W-1:0] m_tag  [N];
  int           m_ptr;
  logic         m_cv;
  logic [W-1:0] m_co;
  int           m_cs;
  logic [N-1:0] last_acc;
  bit           pend   [N];

  cdb_arbiter #(.NUM_SRC(N), .REG_FILE_ADDR_WIDTH(W)) dut (
    .clock    (clock),
    .reset    (reset),
    .flush    (flush),
    .src_valid(src_valid),
    .src_tag  (src_tag),
    .src_ready(src_ready),
    .cdb_valid(cdb_valid),
    .cdb_out  (cdb_out),
    .cdb_src  (cdb_src)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endtask

  // Winner: first full slot in search order, or -1 when all empty.
  function automatic int model_grant();
    for (int k = 0; k < N; k++) begin
      int i;
`ifdef CDB_FIXED_PRIORITY_EN
      i = k;
`else
      i = (m_ptr + k) % N;
`endif
      if (m_full[i]) return i;
    end
    return -1;
  endfunction

  task automatic put(input int i, input logic [W-1:0] t);
    src_valid[i]        = 1'b1;
    src_tag[i*W +: W]   = t;
  endtask

  // One clock: check ready mid-cycle, advance model at the edge, check outputs.
  task automatic step();
    int           g;
    logic [N-1:0] rdy;
    @(negedge clock);
    g = model_grant();
    for (int i = 0; i < N; i++) rdy[i] = !reset && !flush && (!m_full[i] || g == i);
    check("src_ready", 32'(src_ready), 32'(rdy));
    @(posedge clock);
    if (reset || flush) begin
      for (int i = 0; i < N; i++) m_full[i] = 1'b0;
      m_ptr = 0; m_cv = 1'b0; m_co = '0; m_cs = 0;
    end else begin
      if (g >= 0) begin
        m_cv = 1'b1; m_co = m_tag[g]; m_cs = g;
        m_ptr = (g + 1) % N;
        m_full[g] = 1'b0;
      end else begin
        m_cv = 1'b0; m_co = '0; m_cs = 0;
      end
      for (int i = 0; i < N; i++) begin
        if (src_valid[i] && rdy[i]) begin
          m_full[i] = 1'b1;
          m_tag[i]  = src_tag[i*W +: W];
        end
      end
    end
    last_acc = src_valid & rdy;
    #1;
    check("cdb_valid", 32'(cdb_valid), 32'(m_cv));
    check("cdb_out",   32'(cdb_out),   32'(m_co));
    check("cdb_src",   32'(cdb_src),   32'(m_cs));
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; src_valid = '0; src_tag = '0;
    m_ptr = 0; m_cv = 1'b0; m_co = '0; m_cs = 0; last_acc = '0;
    for (int i = 0; i < N; i++) begin m_full[i] = 1'b0; m_tag[i] = '0; pend[i] = 1'b0; end

    // Reset then idle
    step(); step();
    check("rst_cdb_valid", 32'(cdb_valid), 32'd0);
    check("rst_cdb_out",   32'(cdb_out),   32'd0);
    check("rst_cdb_src",   32'(cdb_src),   32'd0);
    reset = 1'b0;
    #1;
    check("idle_ready", 32'(src_ready), 32'hF);
    step();

    // Single source
    put(2, 7'h15);
    step();
    src_valid = '0;
    step();
    check("single_valid", 32'(cdb_valid), 32'd1);
    check("single_out",   32'(cdb_out),   32'h15);
    check("single_src",   32'(cdb_src),   32'd2);
    step();
    check("single_pulse", 32'(cdb_valid), 32'd0);

    // Contention from reset
    reset = 1'b1; step(); reset = 1'b0;
    for (int i = 0; i < N; i++) put(i, 7'(8'h10 + i));
    step();
    src_valid = '0;
    check("cont_ready3_pre", 32'(src_ready[3]), 32'd0);
    for (int k = 0; k < N; k++) begin
      step();
      check("cont_out", 32'(cdb_out), 32'h10 + 32'(k));
      check("cont_src", 32'(cdb_src), 32'(k));
      if (k < N - 1) check("cont_ready3", 32'(src_ready[3]), (k == N - 2) ? 32'd1 : 32'd0);
    end

    // Back-to-back single source
    put(1, 7'h20); step();
    check("b2b_ready_a", 32'(src_ready[1]), 32'd1);
    put(1, 7'h21); step();
    check("b2b_out_a", 32'(cdb_out), 32'h20);
    check("b2b_ready_b", 32'(src_ready[1]), 32'd1);
    put(1, 7'h22); step();
    check("b2b_out_b", 32'(cdb_out), 32'h21);
    src_valid = '0; step();
    check("b2b_out_c", 32'(cdb_out), 32'h22);
    step();
    check("b2b_done", 32'(cdb_valid), 32'd0);

    // Flush mid-operation
    put(0, 7'h01); put(1, 7'h02); put(2, 7'h03); step();
    src_valid = '0; flush = 1'b1; put(0, 7'h05);
    #1;
    check("flush_ready", 32'(src_ready), 32'd0);
    step();
    flush = 1'b0; src_valid = '0;
    check("flush_cv0", 32'(cdb_valid), 32'd0);
    step();
    check("flush_cv1", 32'(cdb_valid), 32'd0);
    step();
    check("flush_cv2", 32'(cdb_valid), 32'd0);

    // Fairness wrap: move pointer to 3 via source 2, then fill slots 0 and 3
    put(2, 7'h30); step();
    src_valid = '0; put(0, 7'h40); put(3, 7'h43); step();
    check("wrap_first", 32'(cdb_src), 32'd2);
    src_valid = '0; step();
`ifdef CDB_FIXED_PRIORITY_EN
    check("wrap_a", 32'(cdb_src), 32'd0);
    check("wrap_a_tag", 32'(cdb_out), 32'h40);
`else
    check("wrap_a", 32'(cdb_src), 32'd3);
    check("wrap_a_tag", 32'(cdb_out), 32'h43);
`endif
    step();
`ifdef CDB_FIXED_PRIORITY_EN
    check("wrap_b", 32'(cdb_src), 32'd3);
`else
    check("wrap_b", 32'(cdb_src), 32'd0);
`endif
    step();

    // Randomized traffic; sources hold offers until accepted
    src_valid = '0;
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      flush = ($urandom_range(0, 39) == 0);
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) != 0) begin
          pend[i] = 1'b1;
          put(i, ($urandom_range(0, 7) == 0) ? 7'h00 : 7'($urandom_range(0, 127)));
        end
      end
      step();
      for (int i = 0; i < N; i++) begin
        if (last_acc[i]) begin
          pend[i]      = 1'b0;
          src_valid[i] = 1'b0;
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
